// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM encoding,
// status-byte bit positions and the configuration word reset value.
package spi_cmd_pkg;

  localparam logic [31:0] CFG_RESET_DEF = 32'hBBFC_0000;
  localparam int          ADDR_W_DEF    = 8;

  localparam logic [7:0] OP_CFG_DEF  = 8'h01;
  localparam logic [7:0] OP_CHAR_DEF = 8'h02;
  localparam logic [7:0] OP_CLR_DEF  = 8'h04;

  // Encoding is visible to the SPI master through the status byte.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPCODE    = 3'd1,
    ST_CFG_DATA  = 3'd2,
    ST_CHAR_ADDR = 3'd3,
    ST_CHAR_DATA = 3'd4,
    ST_IGNORE    = 3'd5
  } state_t;

  // Status byte layout: {state[2:0], 2'b00, abort_seen, frame_err, cfg_loaded}
  localparam int STS_CFG_LOADED = 0;
  localparam int STS_FRAME_ERR  = 1;
  localparam int STS_ABORT_SEEN = 2;
  localparam int STS_STATE_LSB  = 5;

  // Assemble the status byte from its fields.
  function automatic logic [7:0] pack_status(input state_t st, input logic abort_seen,
                                             input logic frame_err, input logic cfg_loaded);
    logic [7:0] v;
    v = 8'h00;
    v[STS_STATE_LSB +: 3] = st;
    v[STS_ABORT_SEEN]     = abort_seen;
    v[STS_FRAME_ERR]      = frame_err;
    v[STS_CFG_LOADED]     = cfg_loaded;
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frames the SPI byte stream into atomic configuration-word updates and
// character-memory write bursts, and produces the MISO status byte.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter logic [31:0] CFG_RESET = CFG_RESET_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0]  OP_CFG    = OP_CFG_DEF,
  parameter logic [7:0]  OP_CHAR   = OP_CHAR_DEF,
  parameter logic [7:0]  OP_CLR    = OP_CLR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [31:0]       config_word,
  output logic              config_update,
  output logic              char_wr_en,
  output logic [ADDR_W-1:0] char_wr_addr,
  output logic [7:0]        char_wr_data,
  output logic [7:0]        tx_data,
  output logic              frame_err
);

  logic              w_ss_sync;
  logic              w_ss_act;

  state_t            r_state;
  logic [31:0]       r_shadow;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_config_word;
  logic              r_config_update;
  logic              r_char_wr_en;
  logic [ADDR_W-1:0] r_char_wr_addr;
  logic [7:0]        r_char_wr_data;
  logic [7:0]        r_tx_data;
  logic              r_frame_err;
  logic              r_abort_seen;
  logic              r_cfg_loaded;

  sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ss_n),
    .o_q   (w_ss_sync)
  );

  assign w_ss_act = ~w_ss_sync;

  // Frame FSM with registered strobes, config word and status byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_shadow        <= 32'h0000_0000;
      r_count         <= 2'd0;
      r_ptr           <= '0;
      r_config_word   <= CFG_RESET;
      r_config_update <= 1'b0;
      r_char_wr_en    <= 1'b0;
      r_char_wr_addr  <= '0;
      r_char_wr_data  <= 8'h00;
      r_tx_data       <= 8'h00;
      r_frame_err     <= 1'b0;
      r_abort_seen    <= 1'b0;
      r_cfg_loaded    <= 1'b0;
    end else begin
      r_config_update <= 1'b0;
      r_char_wr_en    <= 1'b0;
      r_tx_data       <= pack_status(r_state, r_abort_seen, r_frame_err, r_cfg_loaded);
      if (!w_ss_act) begin
        // Frame end beats any byte arriving in the same cycle.
        if (r_state == ST_CFG_DATA) begin
          r_abort_seen <= 1'b1;
          r_frame_err  <= 1'b1;
        end
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_OPCODE;
          ST_OPCODE: begin
            if (rx_valid) begin
              if (rx_data == OP_CFG) begin
                r_count <= 2'd0;
                r_state <= ST_CFG_DATA;
              end else if (rx_data == OP_CHAR) begin
                r_state <= ST_CHAR_ADDR;
              end else if (rx_data == OP_CLR) begin
                r_frame_err  <= 1'b0;
                r_abort_seen <= 1'b0;
                r_state      <= ST_IGNORE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_IGNORE;
              end
            end
          end
          ST_CFG_DATA: begin
            if (rx_valid) begin
              r_shadow <= {r_shadow[23:0], rx_data};
              r_count  <= r_count + 2'd1;
              if (r_count == 2'd3) begin
                r_config_word   <= {r_shadow[23:0], rx_data};
                r_config_update <= 1'b1;
                r_cfg_loaded    <= 1'b1;
                r_state         <= ST_IGNORE;
              end
            end
          end
          ST_CHAR_ADDR: begin
            if (rx_valid) begin
              r_ptr   <= ADDR_W'(rx_data);
              r_state <= ST_CHAR_DATA;
            end
          end
          ST_CHAR_DATA: begin
            if (rx_valid) begin
              r_char_wr_en   <= 1'b1;
              r_char_wr_addr <= r_ptr;
              r_char_wr_data <= rx_data;
              r_ptr          <= r_ptr + 1'b1;
            end
          end
          ST_IGNORE: r_state <= ST_IGNORE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign config_word   = r_config_word;
  assign config_update = r_config_update;
  assign char_wr_en    = r_char_wr_en;
  assign char_wr_addr  = r_char_wr_addr;
  assign char_wr_data  = r_char_wr_data;
  assign tx_data       = r_tx_data;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench: directed frames followed by random frames, each
// compared against a frame-level reference model.
module tb_spi_cmd_decoder;

  localparam logic [31:0] CFG_RST = 32'hBBFC_0000;

  logic        clk;
  logic        rst_n;
  logic        ss_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] config_word;
  logic        config_update;
  logic        char_wr_en;
  logic [7:0]  char_wr_addr;
  logic [7:0]  char_wr_data;
  logic [7:0]  tx_data;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_cfg;
  logic        m_err;
  logic        m_abort;
  logic        m_loaded;
  int          m_upd;
  logic [15:0] m_wr[$];

  // observed activity
  int          o_upd;
  logic [15:0] o_wr[$];

  logic [7:0]  frame_q[$];

  spi_cmd_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ss_n          (ss_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .config_word   (config_word),
    .config_update (config_update),
    .char_wr_en    (char_wr_en),
    .char_wr_addr  (char_wr_addr),
    .char_wr_data  (char_wr_data),
    .tx_data       (tx_data),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record strobes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (config_update) o_upd = o_upd + 1;
    if (char_wr_en) o_wr.push_back({char_wr_addr, char_wr_data});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg    = CFG_RST;
    m_err    = 1'b0;
    m_abort  = 1'b0;
    m_loaded = 1'b0;
  endtask

  // Apply one complete frame (frame_q) to the model.
  task automatic model_frame();
    int n;
    n = frame_q.size();
    if (n == 0) return;
    case (frame_q[0])
      8'h01: begin
        if (n >= 5) begin
          m_cfg    = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
          m_loaded = 1'b1;
          m_upd    = m_upd + 1;
        end else begin
          m_err   = 1'b1;
          m_abort = 1'b1;
        end
      end
      8'h02: begin
        if (n >= 2) begin
          for (int i = 2; i < n; i++) begin
            logic [7:0] a;
            a = 8'((int'(frame_q[1]) + i - 2) % 256);
            m_wr.push_back({a, frame_q[i]});
          end
        end
      end
      8'h04: begin
        m_err   = 1'b0;
        m_abort = 1'b0;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame_open();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_close();
    @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_obs();
    o_upd = 0;
    o_wr.delete();
    m_upd = 0;
    m_wr.delete();
  endtask

  // Compare everything observed since the last clear_obs against the model.
  task automatic check_all(input string tag);
    check_val({tag, ".upd_cnt"}, 32'(o_upd), 32'(m_upd));
    check_val({tag, ".wr_cnt"}, 32'(o_wr.size()), 32'(m_wr.size()));
    for (int i = 0; i < m_wr.size() && i < o_wr.size(); i++)
      check_val({tag, ".wr"}, {16'h0, o_wr[i]}, {16'h0, m_wr[i]});
    check_val({tag, ".cfg"}, config_word, m_cfg);
    check_val({tag, ".ferr"}, {31'h0, frame_err}, {31'h0, m_err});
    check_val({tag, ".tx"}, {24'h0, tx_data}, {24'h0, 5'b00000, m_abort, m_err, m_loaded});
  endtask

  // Send frame_q as one whole frame and check the outcome.
  task automatic run_frame(input string tag);
    clear_obs();
    frame_open();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], $urandom_range(0, 2));
    frame_close();
    model_frame();
    check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    o_upd    = 0;
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    check_val("rst.cfg", config_word, CFG_RST);
    check_val("rst.tx", {24'h0, tx_data}, 32'h0);
    check_val("rst.strobes", {29'h0, config_update, char_wr_en, frame_err}, 32'h0);
    check_val("rst.wr", {16'h0, char_wr_addr, char_wr_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame_q = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame("cfg_ok");

    // Restore reset value so the abort case shows config_word unchanged at BBFC_0000.
    frame_q = '{8'h01, 8'hBB, 8'hFC, 8'h00, 8'h00};
    run_frame("cfg_restore");

    frame_q = '{8'h01, 8'hAA, 8'hBB};
    run_frame("cfg_abort");
    check_val("cfg_abort.word", config_word, 32'hBBFC_0000);

    frame_q = '{8'h04};
    run_frame("clr");

    frame_q = '{8'h02, 8'hFE, 8'h11, 8'h22, 8'h33};
    run_frame("char_wrap");
    check_val("char_wrap.last", {16'h0, char_wr_addr, char_wr_data}, 32'h0000_0033);

    frame_q = '{8'h7E, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame("bad_op");

    frame_q = '{8'h04};
    run_frame("clr2");

    // Reset in the middle of a configuration frame, select held low.
    clear_obs();
    frame_open();
    send_byte(8'h01, 1);
    send_byte(8'h12, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    frame_close();
    frame_q = '{8'h34, 8'h56};
    model_frame();
    check_all("mid_rst");
    check_val("mid_rst.cfg_rst", config_word, CFG_RST);

    // Random frames of every kind.
    for (int f = 0; f < 40; f++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 5);
      frame_q.delete();
      case (kind)
        0: begin
          frame_q.push_back(8'h01);
          len = $urandom_range(4, 6);
          for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
        end
        1: begin
          frame_q.push_back(8'h01);
          len = $urandom_range(0, 3);
          for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
        end
        2: begin
          frame_q.push_back(8'h02);
          frame_q.push_back(8'($urandom_range(248, 255)));
          len = $urandom_range(0, 10);
          for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
        end
        3: frame_q.push_back(8'h04);
        4: begin
          logic [7:0] op;
          op = 8'($urandom);
          if (op == 8'h01 || op == 8'h02 || op == 8'h04) op = 8'hA5;
          frame_q.push_back(op);
          len = $urandom_range(0, 4);
          for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
        end
        default: ;
      endcase
      run_frame("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
